// File: rtl/cpu_pkg.sv
// Shared core types and constants for the MIPS front end.
package cpu_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0]    PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr}; flush empties it in one edge.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  output fetch_entry_t rdata_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: only entries below cnt_q are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end with prefetch FIFO and counter-based redirect discard.
// Optional FETCH_BYPASS_EN: responses reach decode combinationally when the FIFO is empty.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     occ;
  logic            fifo_empty, issue, resp_keep, push, pop;
  fetch_entry_t    head, resp_entry, out_entry;

  // Requests granted but not yet returned plus buffered entries never exceed
  // the FIFO depth, so every kept response has a free slot.
  assign occ       = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign imem_req  = !reset && !redirect_valid && (occ < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;
  assign resp_keep = imem_rvalid && (discard_q == '0) && !redirect_valid;
  assign resp_entry = '{pc: resp_pc_q, instr: imem_rdata};
  assign pop       = !fifo_empty && id_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp       = fifo_empty && resp_keep && !reset;
  assign push      = resp_keep && !(byp && id_ready);
  assign if_valid  = !fifo_empty || byp;
  assign out_entry = fifo_empty ? resp_entry : head;
`else
  assign push      = resp_keep;
  assign if_valid  = !fifo_empty;
  assign out_entry = head;
`endif

  assign if_pc    = if_valid ? out_entry.pc    : '0;
  assign if_instr = if_valid ? out_entry.instr : NOP;

  always_comb begin
    inflight_d = inflight_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (issue)       inflight_d = inflight_d + CW'(1);
    if (imem_rvalid) inflight_d = inflight_d - CW'(1);
    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path.
      discard_d  = inflight_d;
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
    end else begin
      if (imem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
      if (issue)     fetch_pc_d = fetch_pc_q + PC_INC;
      if (resp_keep) resp_pc_d  = resp_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (resp_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );
endmodule
